// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
//   N-channel, W-bit multiplexer with valid/ready handshakes, built-in
//   arbitration and a single registered output stage. One cycle of latency,
//   one word per cycle of throughput.
//
// Parameters:
//   WIDTH     data bits per channel
//   CHANNELS  number of input channels (2..16)
//   MODE      0 = round-robin, 1 = fixed priority (lowest index wins)
//   SELW      width of out_sel, derived from CHANNELS
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected data
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accepts the word
//   out_sel    index of the channel that supplied out_data
// -----------------------------------------------------------------------------
module mux_rr_arb #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
);

  logic [SELW-1:0]     ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;

  logic                grant_found;
  logic [SELW-1:0]     grant_idx;
  logic [CHANNELS-1:0] grant_oh;
  logic [WIDTH-1:0]    grant_data;
  logic                can_accept;
  logic                in_xfer;

  // Circular search starting at ptr_q. In fixed-priority mode ptr_q never
  // leaves 0, so the same search degenerates to lowest-index-wins.
  always_comb begin
    int idx;
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_data  = '0;
    idx         = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_found && in_valid[idx]) begin
        grant_found   = 1'b1;
        grant_idx     = SELW'(idx);
        grant_oh[idx] = 1'b1;
        grant_data    = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // The output register can take a new word if it is empty or being drained
  // this very cycle; that is what gives full throughput without a bubble.
  assign can_accept = !out_valid_q || out_ready;
  assign in_xfer    = !reset && can_accept && grant_found;
  assign in_ready   = (!reset && can_accept) ? grant_oh : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      if (MODE == 0) begin
        ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      // Data and select hold their last values after a drain.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arb
//   Bench for mux_rr_arb. Instance dut_rr runs round-robin (MODE=0) and is
//   checked cycle by cycle against a small arbiter model plus a scoreboard of
//   expected output words. Instance dut_fp runs fixed priority (MODE=1).
// -----------------------------------------------------------------------------
module tb_mux_rr_arb;

  localparam int W = 14;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [N*W-1:0] a_in_data;
  logic [N-1:0]   a_in_valid;
  logic [N-1:0]   a_in_ready;
  logic [W-1:0]   a_out_data;
  logic           a_out_valid;
  logic           a_out_ready;
  logic [1:0]     a_out_sel;

  // Fixed-priority instance
  logic [N*W-1:0] b_in_data;
  logic [N-1:0]   b_in_valid;
  logic [N-1:0]   b_in_ready;
  logic [W-1:0]   b_out_data;
  logic           b_out_valid;
  logic           b_out_ready;
  logic [1:0]     b_out_sel;

  mux_rr_arb #(.WIDTH(W), .CHANNELS(N), .MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sel(a_out_sel)
  );

  mux_rr_arb #(.WIDTH(W), .CHANNELS(N), .MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sel(b_out_sel)
  );

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } word_t;

  word_t        sb[$];
  word_t        sb_fp[$];
  logic [W-1:0] chan_data [N];
  int           model_ptr;
  logic         model_ov;
  int           checks;
  int           errors;

  // Reference arbiter: first valid channel at or after ptr, wrapping.
  function automatic int model_grant(input logic [N-1:0] valid, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle on the round-robin instance: drive inputs after the
  // falling edge, check ready and the presented word, update the model.
  task automatic step(input logic [N-1:0] valid, input logic oready);
    int         g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < N; i++) a_in_data[i*W +: W] = chan_data[i];
    a_in_valid  = valid;
    a_out_ready = oready;
    #1;
    g = (model_ov && !oready) ? -1 : model_grant(valid, model_ptr);
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    checks++;
    if (a_in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b (valid %b)", a_in_ready, exp_ready, valid);
    end
    checks++;
    if (a_out_valid !== model_ov) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", a_out_valid, model_ov);
    end
    if (model_ov) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: output word presented but none expected");
      end else if (a_out_sel !== sb[0].sel || a_out_data !== sb[0].data) begin
        errors++;
        $display("FAIL out_word: got sel %0d data %h expected sel %0d data %h",
                 a_out_sel, a_out_data, sb[0].sel, sb[0].data);
      end
      if (oready && sb.size() != 0) void'(sb.pop_front());
    end
    if (g >= 0) begin
      sb.push_back('{sel: 2'(g), data: chan_data[g]});
      model_ov  = 1'b1;
      model_ptr = (g + 1) % N;
    end else if (model_ov && oready) begin
      model_ov = 1'b0;
    end
  endtask

  // Reset with all channels valid and downstream stalled; checks that
  // ready is forced low during reset and the outputs clear after the edge.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    a_in_valid  = '1;
    a_out_ready = 1'b0;
    b_in_valid  = '1;
    b_out_ready = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== '0 || b_in_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got rr %b fp %b expected 0000", a_in_ready, b_in_ready);
    end
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_sel !== '0) begin
      errors++;
      $display("FAIL reset_out: got valid %b data %h sel %0d expected 0 0 0",
               a_out_valid, a_out_data, a_out_sel);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_out_data !== '0 || b_out_sel !== '0) begin
      errors++;
      $display("FAIL reset_out_fp: got valid %b data %h sel %0d expected 0 0 0",
               b_out_valid, b_out_data, b_out_sel);
    end
    reset      = 1'b0;
    a_in_valid = '0;
    b_in_valid = '0;
    sb.delete();
    sb_fp.delete();
    model_ptr = 0;
    model_ov  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    // Load a word and hold it unconsumed, then reset discards it.
    for (int i = 0; i < N; i++) chan_data[i] = W'(16'h0300 + i);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    do_reset();
  endtask

  task automatic test_single_source();
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = '0;
    chan_data[2] = 14'h1ABC;
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = W'(100 + i);
    for (int k = 0; k < 8; k++) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_wrap_skip();
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = W'(16'h0040 + i);
    step(4'b0100, 1'b1);   // grant 2, ptr moves to 3
    step(4'b0011, 1'b1);   // search from 3 wraps to channel 0
    step(4'b0011, 1'b1);   // ptr now 1, channel 1 wins
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) chan_data[i] = W'(16'h0010 + i);
    chan_data[0] = 14'h0005;
    step(4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);   // drain and accept in the same cycle
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < N; i++) chan_data[i] = W'($urandom);
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);
  endtask

  task automatic test_fixed_priority();
    logic         fp_ov;
    logic [N-1:0] pattern [5];
    logic [N-1:0] exp_ready [5];
    do_reset();
    for (int i = 0; i < N; i++) b_in_data[i*W +: W] = W'(16'h0200 + i);
    pattern   = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000};
    exp_ready = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
    fp_ov = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      b_in_valid  = (k < 5) ? pattern[k] : 4'b0000;
      b_out_ready = 1'b1;
      #1;
      checks++;
      if (b_in_ready !== ((k < 5) ? exp_ready[k] : 4'b0000)) begin
        errors++;
        $display("FAIL fp_in_ready: cycle %0d got %b expected %b", k, b_in_ready,
                 (k < 5) ? exp_ready[k] : 4'b0000);
      end
      checks++;
      if (b_out_valid !== fp_ov) begin
        errors++;
        $display("FAIL fp_out_valid: cycle %0d got %b expected %b", k, b_out_valid, fp_ov);
      end
      if (fp_ov && sb_fp.size() != 0) begin
        checks++;
        if (b_out_sel !== sb_fp[0].sel || b_out_data !== sb_fp[0].data) begin
          errors++;
          $display("FAIL fp_out_word: got sel %0d data %h expected sel %0d data %h",
                   b_out_sel, b_out_data, sb_fp[0].sel, sb_fp[0].data);
        end
        void'(sb_fp.pop_front());
      end
      if (k < 5) begin
        int g;
        g = (k < 4) ? 1 : 3;
        sb_fp.push_back('{sel: 2'(g), data: W'(16'h0200 + g)});
        fp_ov = 1'b1;
      end else begin
        fp_ov = 1'b0;
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_ptr   = 0;
    model_ov    = 1'b0;
    reset       = 1'b1;
    a_in_data   = '0;
    a_in_valid  = '0;
    a_out_ready = 1'b0;
    b_in_data   = '0;
    b_in_valid  = '0;
    b_out_ready = 1'b0;
    for (int i = 0; i < N; i++) chan_data[i] = '0;

    test_reset();
    test_single_source();
    test_rotation();
    test_wrap_skip();
    test_backpressure();
    test_random_traffic();
    test_fixed_priority();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised N-channel, W-bit multiplexer with valid/ready handshakes, a registered output stage and built-in arbitration. It replaces the fixed 14-bit 2:1 combinational select wherever several producers share one datapath. Channel choice comes from an internal round-robin or fixed-priority arbiter, not an external select line. It sits between multiple upstream sources and a single downstream consumer, with one cycle of latency and full throughput.

## Interface
Parameters:
- WIDTH, 14, data bits per channel (≥1).
- CHANNELS, 4, number of input channels (2..16).
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SELW, $clog2(CHANNELS), width of out_sel. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts the word.
- out_sel  output  SELW  index of the channel that supplied out_data.

## Operation
- A transfer on a channel occurs when in_valid[i] & in_ready[i]. The output transfer occurs when out_valid & out_ready.
- can_accept = !out_valid | out_ready. When can_accept is 0, in_ready is all-zero.
- Grant: combinational from in_valid, the priority pointer and MODE.
  - At most one bit of in_ready is high, and only for a channel with in_valid high.
  - If no in_valid bit is set, in_ready is all-zero.
- Round-robin (MODE=0):
  - Search starts at pointer ptr and wraps CHANNELS-1 → 0.
  - After a transfer from channel g, ptr ← (g+1) mod CHANNELS.
  - ptr is unchanged on cycles with no input transfer.
- Fixed priority (MODE=1): the lowest-index valid channel wins. ptr stays 0.
- On an input transfer: out_data ← channel g data, out_sel ← g, out_valid ← 1.
- On an output transfer with no input transfer: out_valid ← 0. out_data and out_sel hold their last values.
- Output stability: while out_valid & !out_ready, out_data and out_sel do not change.
- Simultaneous output drain and input accept in one cycle: out_valid stays 1 and the new word loads, giving no bubble.
- Upstream data is sampled only in the transfer cycle. in_valid may drop without a transfer; no word is created.
- Reset values (next edge with reset=1): out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready is forced all-zero while reset is high.
  - A held, unconsumed word is discarded by reset mid-operation.

## Timing
- Latency: input transfer at edge n → word visible on out_data/out_valid after edge n, presentable downstream in cycle n+1.
- Throughput: one word per cycle when out_ready is held high.
- Paths:
  - in_ready depends combinationally on in_valid, out_valid, out_ready and ptr.
  - out_data, out_valid and out_sel are pure register outputs.
- No combinational path from in_data to any output.
- Fairness (MODE=0): with all channels continuously valid and out_ready=1, each channel is granted exactly once per CHANNELS consecutive cycles.

## Test plan
- Reset: assert reset with in_valid=4'b1111 and out_ready=0 → in_ready=0, out_valid=0, out_data=0, out_sel=0. Hold reset with out_valid=1 → out_valid=0 after the edge.
- Single source, CHANNELS=4, WIDTH=14, MODE=0: in_valid=4'b0100, channel 2 data=14'h1ABC, out_ready=1 → in_ready=4'b0100. Next cycle out_data=14'h1ABC, out_sel=2, out_valid=1.
- Round-robin rotation: in_valid=4'b1111 for 8 cycles, out_ready=1, from reset → grant sequence 0,1,2,3,0,1,2,3. Channel i data=i+100 gives out_data sequence 100,101,102,103,100,….
- Wrap/skip: ptr=3, in_valid=4'b0011 → channel 0 granted, then ptr=1, then channel 1 granted.
- Backpressure: out_valid=1 with out_data=14'h0005, out_ready=0 for 3 cycles, in_valid=4'b1111 → in_ready=0 and out_data stays 14'h0005. Raise out_ready → same-cycle accept, next word loads with no bubble.
- Fixed priority, MODE=1: in_valid=4'b1010 for 4 cycles, out_ready=1 → channel 1 granted every cycle and channel 3 is never granted. Then in_valid=4'b1000 → channel 3 granted.
